// File: rtl/vanilla_sb_clear_scheduler.sv
// Arbitrates writeback scoreboard-clear requests onto one int and one float clear port per cycle.
// Define VANILLA_SB_CLEAR_SCHED_FIXED_PRIO_EN for fixed-priority (lowest index wins) arbitration.
module vanilla_sb_clear_scheduler #(
  parameter int unsigned num_src_p        = 3,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned count_width_p    = 32
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_src_p-1:0]                  src_v_i,
  input  logic [num_src_p-1:0]                  src_float_i,
  input  logic [num_src_p*reg_addr_width_p-1:0] src_id_i,
  output logic [num_src_p-1:0]                  src_yumi_o,
  input  logic                                  stall_all_i,
  output logic                                  int_sb_clear_o,
  output logic [reg_addr_width_p-1:0]           int_sb_clear_id_o,
  output logic                                  float_sb_clear_o,
  output logic [reg_addr_width_p-1:0]           float_sb_clear_id_o,
  output logic [count_width_p-1:0]              int_clear_count_o,
  output logic [count_width_p-1:0]              float_clear_count_o
);

  localparam int unsigned PtrW  = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int unsigned PtrW1 = PtrW + 1;
  localparam logic [PtrW:0]   NumSrcW = PtrW1'(num_src_p);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(num_src_p - 1);

  typedef struct packed {
    logic            v;
    logic [PtrW-1:0] idx;
  } pick_t;

  // First requester at or after ptr, searching upward and wrapping past the last source.
  function automatic pick_t rr_pick(input logic [num_src_p-1:0] req, input logic [PtrW-1:0] ptr);
    pick_t         res;
    logic [PtrW:0] cand;
    res = '0;
    for (int unsigned k = 0; k < num_src_p; k++) begin
      cand = {1'b0, ptr} + PtrW1'(k);
      if (cand >= NumSrcW) cand = cand - NumSrcW;
      if (!res.v && req[cand[PtrW-1:0]]) begin
        res.v   = 1'b1;
        res.idx = cand[PtrW-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [reg_addr_width_p-1:0] id_sel(
    input logic [num_src_p*reg_addr_width_p-1:0] ids,
    input logic [PtrW-1:0]                       idx
  );
    logic [reg_addr_width_p-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      if (idx == PtrW'(i)) res = ids[i*reg_addr_width_p +: reg_addr_width_p];
    end
    return res;
  endfunction

  logic [num_src_p-1:0] int_req, float_req;
  pick_t                int_pick, float_pick;
  logic                 grant_en, int_gnt, float_gnt;

`ifdef VANILLA_SB_CLEAR_SCHED_FIXED_PRIO_EN
  always_comb begin
    int_pick   = rr_pick(int_req, '0);
    float_pick = rr_pick(float_req, '0);
  end
`else
  logic [PtrW-1:0] rr_int_q, rr_int_d, rr_float_q, rr_float_d;

  always_comb begin
    int_pick   = rr_pick(int_req, rr_int_q);
    float_pick = rr_pick(float_req, rr_float_q);
    rr_int_d   = rr_int_q;
    rr_float_d = rr_float_q;
    if (int_gnt) rr_int_d = (int_pick.idx == LastIdx) ? '0 : int_pick.idx + 1'b1;
    if (float_gnt) rr_float_d = (float_pick.idx == LastIdx) ? '0 : float_pick.idx + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_int_q   <= '0;
      rr_float_q <= '0;
    end else begin
      rr_int_q   <= rr_int_d;
      rr_float_q <= rr_float_d;
    end
  end
`endif

  // Grants are suppressed during reset so a request in the reset cycle is never consumed.
  always_comb begin
    int_req    = src_v_i & ~src_float_i;
    float_req  = src_v_i & src_float_i;
    grant_en   = ~stall_all_i & ~reset_i;
    int_gnt    = int_pick.v & grant_en;
    float_gnt  = float_pick.v & grant_en;
    src_yumi_o = '0;
    if (int_gnt) src_yumi_o[int_pick.idx] = 1'b1;
    if (float_gnt) src_yumi_o[float_pick.idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      int_sb_clear_o      <= 1'b0;
      int_sb_clear_id_o   <= '0;
      float_sb_clear_o    <= 1'b0;
      float_sb_clear_id_o <= '0;
      int_clear_count_o   <= '0;
      float_clear_count_o <= '0;
    end else begin
      int_sb_clear_o   <= int_gnt;
      float_sb_clear_o <= float_gnt;
      if (int_gnt) begin
        int_sb_clear_id_o <= id_sel(src_id_i, int_pick.idx);
        int_clear_count_o <= int_clear_count_o + count_width_p'(1);
      end
      if (float_gnt) begin
        float_sb_clear_id_o <= id_sel(src_id_i, float_pick.idx);
        float_clear_count_o <= float_clear_count_o + count_width_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_vanilla_sb_clear_scheduler.sv
// Table-driven bench with a clear-strobe scoreboard for vanilla_sb_clear_scheduler.
module tb_vanilla_sb_clear_scheduler;

  localparam int unsigned NumSrc = 3;
  localparam int unsigned IdW    = 5;
  localparam int unsigned CntW   = 4;

  logic                    clk_i = 1'b0;
  logic                    reset_i;
  logic [NumSrc-1:0]       src_v_i, src_float_i, src_yumi_o;
  logic [NumSrc*IdW-1:0]   src_id_i;
  logic                    stall_all_i;
  logic                    int_sb_clear_o, float_sb_clear_o;
  logic [IdW-1:0]          int_sb_clear_id_o, float_sb_clear_id_o;
  logic [CntW-1:0]         int_clear_count_o, float_clear_count_o;

  always #5 clk_i = ~clk_i;

  vanilla_sb_clear_scheduler #(
    .num_src_p        (NumSrc),
    .reg_addr_width_p (IdW),
    .count_width_p    (CntW)
  ) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .src_v_i             (src_v_i),
    .src_float_i         (src_float_i),
    .src_id_i            (src_id_i),
    .src_yumi_o          (src_yumi_o),
    .stall_all_i         (stall_all_i),
    .int_sb_clear_o      (int_sb_clear_o),
    .int_sb_clear_id_o   (int_sb_clear_id_o),
    .float_sb_clear_o    (float_sb_clear_o),
    .float_sb_clear_id_o (float_sb_clear_id_o),
    .int_clear_count_o   (int_clear_count_o),
    .float_clear_count_o (float_clear_count_o)
  );

  typedef struct {
    logic           is_float;
    logic [IdW-1:0] id;
    int             due;
  } clr_t;

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  fl;
    logic [14:0] ids;
    logic        stall;
    logic [2:0]  yumi_rr;
    logic [2:0]  yumi_fp;
  } vec_t;

  clr_t            exp_q[$];
  vec_t            tbl[19];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              int_total = 0;
  logic [IdW-1:0]  exp_int_id, exp_fl_id;
  logic [CntW-1:0] exp_int_cnt, exp_fl_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_int_id  = '0;
    exp_fl_id   = '0;
    exp_int_cnt = '0;
    exp_fl_cnt  = '0;
  endtask

  // Registered outputs seen this cycle must match the grants expected last cycle.
  task automatic check_outputs();
    clr_t c;
    logic ei, ef;
    ei = 1'b0;
    ef = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      c = exp_q.pop_front();
      if (c.is_float) begin
        ef = 1'b1;
        exp_fl_id = c.id;
        exp_fl_cnt++;
      end else begin
        ei = 1'b1;
        exp_int_id = c.id;
        exp_int_cnt++;
      end
    end
    chk("int_strobe", 32'(int_sb_clear_o), 32'(ei));
    chk("float_strobe", 32'(float_sb_clear_o), 32'(ef));
    chk("int_id", 32'(int_sb_clear_id_o), 32'(exp_int_id));
    chk("float_id", 32'(float_sb_clear_id_o), 32'(exp_fl_id));
    chk("int_count", 32'(int_clear_count_o), 32'(exp_int_cnt));
    chk("float_count", 32'(float_clear_count_o), 32'(exp_fl_cnt));
  endtask

  task automatic step(input logic [2:0] v, input logic [2:0] fl, input logic [14:0] ids,
                      input logic stall, input logic [2:0] exp_yumi);
    clr_t c;
    @(negedge clk_i);
    reset_i     = 1'b0;
    src_v_i     = v;
    src_float_i = fl;
    src_id_i    = ids;
    stall_all_i = stall;
    #1;
    check_outputs();
    chk("yumi", 32'(src_yumi_o), 32'(exp_yumi));
    for (int i = 0; i < 3; i++) begin
      if (exp_yumi[i]) begin
        c.is_float = fl[i];
        c.id       = ids[i*IdW +: IdW];
        c.due      = cyc + 1;
        exp_q.push_back(c);
        if (!fl[i]) int_total++;
      end
    end
    cyc++;
  endtask

  task automatic reset_cycle();
    @(negedge clk_i);
    reset_i     = 1'b1;
    src_v_i     = 3'b111;
    src_float_i = 3'b010;
    src_id_i    = {5'd21, 5'd22, 5'd23};
    stall_all_i = 1'b0;
    #1;
    check_outputs();
    chk("yumi_in_reset", 32'(src_yumi_o), 32'd0);
    cyc++;
    reset_model();
  endtask

  initial begin
    logic [2:0] ey;
    tbl[0]  = '{3'b111, 3'b000, {5'd7, 5'd6, 5'd5}, 1'b0, 3'b001, 3'b001};
    tbl[1]  = '{3'b111, 3'b000, {5'd7, 5'd6, 5'd5}, 1'b0, 3'b010, 3'b001};
    tbl[2]  = '{3'b111, 3'b000, {5'd7, 5'd6, 5'd5}, 1'b0, 3'b100, 3'b001};
    tbl[3]  = '{3'b111, 3'b000, {5'd7, 5'd6, 5'd5}, 1'b0, 3'b001, 3'b001};
    tbl[4]  = '{3'b011, 3'b010, {5'd0, 5'd9, 5'd3}, 1'b0, 3'b011, 3'b011};
    tbl[5]  = '{3'b100, 3'b000, {5'd12, 5'd0, 5'd0}, 1'b1, 3'b000, 3'b000};
    tbl[6]  = '{3'b100, 3'b000, {5'd12, 5'd0, 5'd0}, 1'b1, 3'b000, 3'b000};
    tbl[7]  = '{3'b100, 3'b000, {5'd12, 5'd0, 5'd0}, 1'b1, 3'b000, 3'b000};
    tbl[8]  = '{3'b100, 3'b000, {5'd12, 5'd0, 5'd0}, 1'b0, 3'b100, 3'b100};
    tbl[9]  = '{3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b100, 3'b001};
    tbl[10] = '{3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b001, 3'b001};
    tbl[11] = '{3'b111, 3'b101, {5'd8, 5'd4, 5'd0}, 1'b0, 3'b110, 3'b011};
    tbl[12] = '{3'b000, 3'b000, {5'd0, 5'd0, 5'd0}, 1'b0, 3'b000, 3'b000};
    tbl[13] = '{3'b010, 3'b000, {5'd0, 5'd0, 5'd0}, 1'b0, 3'b010, 3'b010};
    tbl[14] = '{3'b011, 3'b000, {5'd0, 5'd11, 5'd10}, 1'b0, 3'b001, 3'b001};
    tbl[15] = '{3'b011, 3'b000, {5'd0, 5'd11, 5'd10}, 1'b0, 3'b010, 3'b001};
    tbl[16] = '{3'b011, 3'b000, {5'd0, 5'd11, 5'd10}, 1'b0, 3'b001, 3'b001};
    tbl[17] = '{3'b011, 3'b000, {5'd0, 5'd11, 5'd10}, 1'b0, 3'b010, 3'b001};
    tbl[18] = '{3'b000, 3'b000, {5'd0, 5'd0, 5'd0}, 1'b0, 3'b000, 3'b000};

    reset_i     = 1'b1;
    src_v_i     = '0;
    src_float_i = '0;
    src_id_i    = '0;
    stall_all_i = 1'b0;
    reset_model();
    repeat (2) @(posedge clk_i);

    repeat (5) step(3'b000, 3'b000, 15'd0, 1'b0, 3'b000);

    for (int i = 0; i < 19; i++) begin
`ifdef VANILLA_SB_CLEAR_SCHED_FIXED_PRIO_EN
      ey = tbl[i].yumi_fp;
`else
      ey = tbl[i].yumi_rr;
`endif
      step(tbl[i].v, tbl[i].fl, tbl[i].ids, tbl[i].stall, ey);
    end

    // Drive the 4-bit int counter through its wrap: 17 clears must read back as 1.
    while (int_total < 17) step(3'b001, 3'b000, {5'd0, 5'd0, 5'd20}, 1'b0, 3'b001);
    step(3'b000, 3'b000, 15'd0, 1'b0, 3'b000);
    chk("int_count_wrap", 32'(int_clear_count_o), 32'd1);
    chk("float_count_total", 32'(float_clear_count_o), 32'd4);

    // Mid-stream reset: the grant before reset still strobes, the reset-cycle request does not.
    step(3'b001, 3'b000, {5'd0, 5'd0, 5'd17}, 1'b0, 3'b001);
    reset_cycle();
    step(3'b111, 3'b000, {5'd7, 5'd6, 5'd5}, 1'b0, 3'b001);
    step(3'b000, 3'b000, 15'd0, 1'b0, 3'b000);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
